// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared types and constants for the 12-bit-address program
//               counter.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

  // Default program counter / jump target width in bits.
  localparam int PC_W = 12;

  typedef logic [PC_W-1:0] pc_t;

  // Value the program counter takes on reset.
  localparam pc_t PC_RESET = '0;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_if
// Description : Control/address bundle between the controller/branch logic
//               (master) and the program counter (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_if
  import pc_pkg::*;
#(
  parameter int D = PC_W
);

  logic         absjump_en;  // load target at the next rising edge
  logic         nextFlag;    // advance by one at the next rising edge
  logic [D-1:0] target;      // absolute jump destination
  logic [D-1:0] prog_ctr;    // current program counter value

  // Controller side: issues jump/advance requests, observes the address.
  modport master (
    output absjump_en,
    output nextFlag,
    output target,
    input  prog_ctr
  );

  // Program counter side.
  modport slave (
    input  absjump_en,
    input  nextFlag,
    input  target,
    output prog_ctr
  );

endinterface : pc_if
`default_nettype wire

// File: rtl/pc.sv
`default_nettype none
// ============================================================================
// Module      : pc
// Description : Program counter. Holds the address of the instruction being
//               fetched; loads an absolute jump target or advances by one.
//               Priority: reset > jump > increment > hold.
// Revision    : 1.0 - initial release
// ============================================================================
module pc
  import pc_pkg::*;
#(
  parameter int D = PC_W
) (
  input  wire logic clk,
  input  wire logic reset,
  pc_if.slave       bus
);

  // Width must allow at least one address bit.
  generate
    if (D < 1) begin : g_bad_width
      $error("pc: parameter D must be >= 1");
    end
  endgenerate

  logic [D-1:0] r_prog_ctr;

  // Program counter register with reset > jump > increment > hold priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prog_ctr <= D'(PC_RESET);
    end else if (bus.absjump_en) begin
      r_prog_ctr <= bus.target;
    end else if (bus.nextFlag) begin
      r_prog_ctr <= r_prog_ctr + 1'b1;  // carry discarded: wraps to 0
    end
  end

  assign bus.prog_ctr = r_prog_ctr;

  // Behavioural properties of the next-value selection.
  a_reset : assert property (@(posedge clk)
    reset |=> (r_prog_ctr == D'(PC_RESET)));

  a_jump : assert property (@(posedge clk)
    (!reset && bus.absjump_en) |=> (r_prog_ctr == $past(bus.target)));

  a_incr : assert property (@(posedge clk)
    (!reset && !bus.absjump_en && bus.nextFlag)
      |=> (r_prog_ctr == D'($past(r_prog_ctr) + 1'b1)));

  a_hold : assert property (@(posedge clk)
    (!reset && !bus.absjump_en && !bus.nextFlag)
      |=> (r_prog_ctr == $past(r_prog_ctr)));

endmodule : pc
`default_nettype wire

// File: tb/tb_pc.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc
// Description : Directed self-checking bench for the program counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc;
  import pc_pkg::*;

  localparam int D = 12;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  pc_if #(.D(D)) bus ();

  pc #(.D(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one set of controls across a single rising edge, then let the
  // register settle before the caller samples.
  task automatic step(input logic rst_v, input logic jmp_v, input logic nxt_v,
                      input logic [D-1:0] tgt_v);
    reset          = rst_v;
    bus.absjump_en = jmp_v;
    bus.nextFlag   = nxt_v;
    bus.target     = tgt_v;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [D-1:0] exp_v);
    n_vec++;
    assert (bus.prog_ctr === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, bus.prog_ctr, exp_v);
    end
  endtask

  initial begin
    n_vec          = 0;
    n_err          = 0;
    reset          = 1'b1;
    bus.absjump_en = 1'b1;
    bus.nextFlag   = 1'b1;
    bus.target     = 12'hABC;

    // Reset wins over simultaneous jump and increment.
    step(1'b1, 1'b1, 1'b1, 12'hABC);
    check("reset", 12'h000);

    // Increment after reset release.
    step(1'b0, 1'b0, 1'b1, 12'h000);
    check("incr_1", 12'h001);
    step(1'b0, 1'b0, 1'b1, 12'h000);
    check("incr_2", 12'h002);
    step(1'b0, 1'b0, 1'b1, 12'h000);
    check("incr_3", 12'h003);

    // Hold for five edges; target changes must not leak through.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 12'h5A5);
      check("hold", 12'h003);
    end

    // Jump wins over increment: exactly target, not target+1.
    step(1'b0, 1'b1, 1'b1, 12'h7F0);
    check("jump_prio", 12'h7F0);
    step(1'b0, 1'b0, 1'b1, 12'h000);
    check("jump_then_incr", 12'h7F1);

    // Wrap-around at the top of the address space.
    step(1'b0, 1'b1, 1'b0, 12'hFFF);
    check("jump_top", 12'hFFF);
    step(1'b0, 1'b0, 1'b1, 12'h123);
    check("wrap", 12'h000);

    // Jump to the current address simply holds.
    step(1'b0, 1'b1, 1'b0, 12'h000);
    check("jump_self", 12'h000);

    // Count up to 5, then reset mid-run alongside a jump.
    step(1'b0, 1'b1, 1'b0, 12'h004);
    check("jump_4", 12'h004);
    step(1'b0, 1'b0, 1'b1, 12'h000);
    check("incr_5", 12'h005);
    step(1'b1, 1'b1, 1'b1, 12'h100);
    check("reset_mid", 12'h000);
    step(1'b0, 1'b0, 1'b1, 12'h100);
    check("after_reset", 12'h001);

    // Arbitrary target loaded verbatim, then held.
    step(1'b0, 1'b1, 1'b0, 12'hA5A);
    check("jump_a5a", 12'hA5A);
    step(1'b0, 1'b0, 1'b0, 12'h000);
    check("hold_a5a", 12'hA5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pc
`default_nettype wire
